bst_update_ctrl: RTL and testbench

Update-side controller for the branch status table (BST). It records every prediction the fetch stage issues (table index, 2-bit status read out, predicted target), holds them in order until the execute stage resolves each branch, then computes the new saturating-counter state and target and drives the BST write port (`en_2`, `PC_index_update`, `status_update`, `PC_predict_update`). It sits between the fetch-side BST read port and the execute-stage branch unit and flags mispredictions back to the pipeline.

---
 rtl/bst_update_ctrl.sv | 93 +++++++++
 tb/tb_bst_update_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/bst_update_ctrl.sv
// bst_update_ctrl: in-order BST prediction tracker driving the BST write port; optional BST_UPD_STATS_EN adds resolve/mispredict counters.
module bst_update_ctrl #(
  parameter int DEPTH  = 4,
  parameter int IDX_W  = 14,
  parameter int ADDR_W = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [IDX_W-1:0]             push_index,
  input  logic [1:0]                   push_status,
  input  logic [ADDR_W-1:0]            push_target,
  input  logic                         resolve,
  input  logic                         resolve_taken,
  input  logic [ADDR_W-1:0]            resolve_target,
  input  logic                         flush,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         wr_en,
  output logic [IDX_W-1:0]             wr_index,
  output logic [1:0]                   wr_status,
  output logic [ADDR_W-1:0]            wr_target,
  output logic                         mispredict
`ifdef BST_UPD_STATS_EN
  ,
  output logic [31:0]                  stat_resolved,
  output logic [31:0]                  stat_mispred
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [IDX_W-1:0]  idx_mem [DEPTH];
  logic [1:0]        st_mem  [DEPTH];
  logic [ADDR_W-1:0] tg_mem  [DEPTH];
  logic [PW-1:0]     head, tail;
  logic [CW-1:0]     next_count;
  logic [1:0]        head_st, next_st;
  logic [ADDR_W-1:0] head_tg;
  logic              pop, ins, mis;
  always_comb begin
    pop        = resolve && count != '0;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
    ins        = push && !flush && (!full || pop);
    head_st    = st_mem[head];
    head_tg    = tg_mem[head];
    next_st    = resolve_taken ? (head_st == 2'b11 ? head_st : head_st + 2'd1)
                               : (head_st == 2'b00 ? head_st : head_st - 2'd1);
    mis        = (head_st[1] != resolve_taken) || (resolve_taken && resolve_target != head_tg);
    next_count = flush ? '0 : count + CW'(ins) - CW'(pop);
  end
  always_ff @(posedge clk)
    if (ins) begin
      idx_mem[tail] <= push_index;
      st_mem[tail]  <= push_status;
      tg_mem[tail]  <= push_target;
    end
  always_ff @(posedge clk) begin
    if (rst) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      full       <= 1'b0;
      wr_en      <= 1'b0;
      wr_index   <= '0;
      wr_status  <= '0;
      wr_target  <= '0;
      mispredict <= 1'b0;
    end else begin
      head       <= flush ? '0 : head + PW'(pop);
      tail       <= flush ? '0 : tail + PW'(ins);
      count      <= next_count;
      full       <= next_count == CW'(DEPTH);
      wr_en      <= pop;
      mispredict <= pop && mis;
      if (pop) begin
        wr_index  <= idx_mem[head];
        wr_status <= next_st;
        wr_target <= resolve_taken ? resolve_target : head_tg;
      end
    end
  end
`ifdef BST_UPD_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_resolved <= '0;
      stat_mispred  <= '0;
    end else begin
      stat_resolved <= stat_resolved + 32'(pop);
      stat_mispred  <= stat_mispred + 32'(pop && mis);
    end
  end
`endif
endmodule

// File: tb/tb_bst_update_ctrl.sv
// tb_bst_update_ctrl: directed and random checks of bst_update_ctrl against a queue-based reference.
module tb_bst_update_ctrl;
  localparam int DEPTH = 4;
  logic        clk = 0, rst = 0;
  logic        push = 0, resolve = 0, resolve_taken = 0, flush = 0;
  logic [13:0] push_index = 0;
  logic [1:0]  push_status = 0;
  logic [31:0] push_target = 0, resolve_target = 0;
  logic        full, wr_en, mispredict;
  logic [2:0]  count;
  logic [13:0] wr_index;
  logic [1:0]  wr_status;
  logic [31:0] wr_target;
`ifdef BST_UPD_STATS_EN
  logic [31:0] stat_resolved, stat_mispred;
`endif
  typedef struct {logic [13:0] idx; logic [1:0] st; logic [31:0] tg;} ent_t;
  ent_t        q[$];
  logic        e_en, e_mis;
  logic [13:0] e_idx;
  logic [1:0]  e_st;
  logic [31:0] e_tg, s_res, s_mis;
  int          total = 0, bad = 0;

  bst_update_ctrl #(.DEPTH(DEPTH), .IDX_W(14), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .push(push), .push_index(push_index), .push_status(push_status),
    .push_target(push_target), .resolve(resolve), .resolve_taken(resolve_taken),
    .resolve_target(resolve_target), .flush(flush), .full(full), .count(count),
    .wr_en(wr_en), .wr_index(wr_index), .wr_status(wr_status), .wr_target(wr_target),
    .mispredict(mispredict)
`ifdef BST_UPD_STATS_EN
    , .stat_resolved(stat_resolved), .stat_mispred(stat_mispred)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic p, input logic [13:0] pi, input logic [1:0] ps, input logic [31:0] pt,
                      input logic r, input logic rt, input logic [31:0] rtg, input logic f, input logic rs);
    ent_t h;
    int   s;
    push = p; push_index = pi; push_status = ps; push_target = pt;
    resolve = r; resolve_taken = rt; resolve_target = rtg; flush = f; rst = rs;
    @(posedge clk);
    #1;
    if (rs) begin
      q.delete();
      e_en = 0; e_mis = 0; e_idx = 0; e_st = 0; e_tg = 0; s_res = 0; s_mis = 0;
    end else begin
      e_en = 0; e_mis = 0;
      if (r && q.size() > 0) begin
        h = q.pop_front();
        s = int'(h.st);
        s = rt ? (s + 1 > 3 ? 3 : s + 1) : (s - 1 < 0 ? 0 : s - 1);
        e_en = 1; e_idx = h.idx; e_st = 2'(s);
        e_tg = rt ? rtg : h.tg;
        e_mis = ((h.st >= 2'd2) != rt) || (rt && rtg != h.tg);
        s_res++;
        if (e_mis) s_mis++;
      end
      if (f) q.delete();
      else if (p && q.size() < DEPTH) q.push_back('{pi, ps, pt});
    end
    chk("wr_en", wr_en, e_en);
    chk("mispredict", mispredict, e_mis);
    chk("count", count, q.size());
    chk("full", full, q.size() == DEPTH);
    chk("wr_index", wr_index, e_idx);
    chk("wr_status", wr_status, e_st);
    chk("wr_target", wr_target, e_tg);
`ifdef BST_UPD_STATS_EN
    chk("stat_resolved", stat_resolved, s_res);
    chk("stat_mispred", stat_mispred, s_mis);
`endif
  endtask

  task automatic psh(input logic [13:0] pi, input logic [1:0] ps, input logic [31:0] pt);
    step(1, pi, ps, pt, 0, 0, 0, 0, 0);
  endtask

  task automatic res(input logic rt, input logic [31:0] rtg);
    step(0, 0, 0, 0, 1, rt, rtg, 0, 0);
  endtask

  initial begin
    logic [31:0] hint;
    step(1, 14'h3fff, 2'b11, 32'hffff, 1, 1, 32'h1, 1, 1);
    chk("reset_wr_en", wr_en, 0);
    chk("reset_count", count, 0);
    psh(14'h0005, 2'b01, 32'h100);
    res(1, 32'h200);
    chk("tp1_wr_en", wr_en, 1);
    chk("tp1_index", wr_index, 14'h0005);
    chk("tp1_status", wr_status, 2'b10);
    chk("tp1_target", wr_target, 32'h200);
    chk("tp1_mispredict", mispredict, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("tp1_wr_en_drop", wr_en, 0);
    chk("tp1_hold_target", wr_target, 32'h200);
    psh(14'h0011, 2'b11, 32'h300);
    res(1, 32'h300);
    chk("sat_hi_status", wr_status, 2'b11);
    chk("sat_hi_mis", mispredict, 0);
    psh(14'h0022, 2'b00, 32'h400);
    res(0, 32'h999);
    chk("sat_lo_status", wr_status, 2'b00);
    chk("sat_lo_mis", mispredict, 0);
    chk("sat_lo_target", wr_target, 32'h400);
    for (int i = 0; i < 4; i++) psh(14'(i + 1), 2'(i), 32'(16 * i));
    chk("fill_full", full, 1);
    chk("fill_count", count, 4);
    psh(14'h0abc, 2'b10, 32'hdead);
    chk("drop_count", count, 4);
    step(1, 14'h0077, 2'b10, 32'h770, 1, 0, 0, 0, 0);
    chk("pr_count", count, 4);
    chk("pr_index", wr_index, 14'h0001);
    for (int i = 0; i < 4; i++) res(1, 32'(16 * i));
    chk("wrap_last_index", wr_index, 14'h0077);
    res(1, 32'h5);
    chk("empty_wr_en", wr_en, 0);
    chk("empty_count", count, 0);
    for (int i = 0; i < 3; i++) psh(14'(i + 8), 2'b10, 32'h80);
    step(1, 14'h0fff, 2'b01, 32'h1, 1, 1, 32'h80, 1, 0);
    chk("flush_wr_en", wr_en, 1);
    chk("flush_index", wr_index, 14'h0008);
    chk("flush_count", count, 0);
    res(1, 32'h80);
    chk("post_flush_wr_en", wr_en, 0);
    psh(14'h0033, 2'b10, 32'h330);
    psh(14'h0034, 2'b01, 32'h340);
    step(1, 14'h0035, 2'b11, 32'h350, 1, 0, 0, 0, 1);
    chk("rst_mid_wr_en", wr_en, 0);
    chk("rst_mid_index", wr_index, 0);
    for (int i = 0; i < 10; i++) begin
      psh(14'(i), 2'b10, 32'h40);
      res(i % 3 != 0 || i == 9, 32'h40);
    end
`ifdef BST_UPD_STATS_EN
    chk("stats_resolved10", stat_resolved, 10);
    chk("stats_mispred3", stat_mispred, 3);
`endif
    for (int i = 0; i < 3000; i++) begin
      hint = (q.size() > 0 && $urandom_range(0, 1) == 1) ? q[0].tg : 32'($urandom_range(0, 7));
      step($urandom_range(0, 99) < 55, 14'($urandom), 2'($urandom), 32'($urandom_range(0, 7)),
           $urandom_range(0, 99) < 45, 1'($urandom), hint,
           $urandom_range(0, 99) < 3, $urandom_range(0, 999) < 4);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
